hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage datapath: decides stage enables and bubble insertion each cycle from memory handshakes, register dependences and resolved control flow. Adds an in-flight destination scoreboard for RAW detection, optional forwarding-select generation with load-use-only stalling, a multi-cycle branch flush sequencer and a saturating stall counter. Sits beside the pipeline latches; its enables and flushes drive the fetch/decode, decode/execute, execute/memory and memory/writeback latches.

---
 rtl/hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller
//
// Purpose: produces the four pipeline latch enables, the decode and execute
// bubble flushes, and the forwarding selects each cycle. It works from the
// memory handshakes, a scoreboard of in-flight destinations and the resolved
// control flow. It also keeps a saturating count of fetch-stall cycles.
//
// Ports:
//   CLK, nRST         clock (rising edge), asynchronous active-low reset
//   ihit              instruction fetch word returned this cycle
//   dreq, dhit        memory-stage access pending / completed
//   rs_valid, rs      decode source register rs and its read enable
//   rt_valid, rt      decode source register rt and its read enable
//   rd_wen, rd        decode destination register and its write enable
//   rd_load           decode instruction is a load
//   br_taken          execute resolved a taken branch or jump
//   fetch_en, decode_en, execute_en, memory_en
//                     latch enables, fetch/decode through memory/writeback
//   dflush, eflush    bubble into the fetch/decode and decode/execute latches
//   fwd_rs, fwd_rt    0 = register file, k = scoreboard entry k-1
//   stall_cycles      saturating count of cycles with fetch_en low
module hazard_ctrl #(
   parameter int REGS         = 32,
   parameter int DEPTH        = 3,
   parameter int FWD          = 0,
   parameter int FLUSH_CYCLES = 1,
   localparam int AW          = $clog2(REGS)
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          ihit,
   input  logic          dreq,
   input  logic          dhit,
   input  logic          rs_valid,
   input  logic          rt_valid,
   input  logic [AW-1:0] rs,
   input  logic [AW-1:0] rt,
   input  logic          rd_wen,
   input  logic [AW-1:0] rd,
   input  logic          rd_load,
   input  logic          br_taken,
   output logic          fetch_en,
   output logic          decode_en,
   output logic          execute_en,
   output logic          memory_en,
   output logic          dflush,
   output logic          eflush,
   output logic [2:0]    fwd_rs,
   output logic [2:0]    fwd_rt,
   output logic [15:0]   stall_cycles
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   // The branch cycle itself is the first bubble, so the counter only
   // covers the remaining FLUSH_CYCLES-1 cycles.
   localparam logic [1:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

   state_t             state_q, state_d;
   logic [1:0]         fcnt_q, fcnt_d;
   logic [DEPTH-1:0]   sb_valid_q, sb_valid_d;
   logic [DEPTH-1:0]   sb_load_q, sb_load_d;
   logic [AW-1:0]      sb_reg_q [DEPTH];
   logic [AW-1:0]      sb_reg_d [DEPTH];
   logic [15:0]        stall_q, stall_d;

   logic [DEPTH-1:0]   match_rs, match_rt;
   logic               raw_hit, data_wait, raw_stall;
   logic               f_en, d_en, e_en, m_en, dfl, efl;
   logic [2:0]         fwd_rs_c, fwd_rt_c;

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         match_rs[k] = rs_valid && (rs != '0) && sb_valid_q[k] && (sb_reg_q[k] == rs);
         match_rt[k] = rt_valid && (rt != '0) && sb_valid_q[k] && (sb_reg_q[k] == rt);
      end
   end

   // With forwarding, only a load still in execute cannot be bypassed.
   assign raw_hit   = (FWD != 0) ? ((match_rs[0] || match_rt[0]) && sb_load_q[0])
                                 : ((|match_rs) || (|match_rt));
   assign data_wait = dreq && !dhit;

   always_comb begin
      f_en      = 1'b1;
      d_en      = 1'b1;
      e_en      = 1'b1;
      m_en      = 1'b1;
      dfl       = 1'b0;
      efl       = 1'b0;
      raw_stall = 1'b0;
      state_d   = state_q;
      fcnt_d    = fcnt_q;
      if (data_wait) begin
         // Freezes everything, including a pending branch, which the
         // datapath keeps asserted until the access completes.
         f_en = 1'b0;
         d_en = 1'b0;
         e_en = 1'b0;
         m_en = 1'b0;
      end else if (br_taken) begin
         dfl = 1'b1;
         efl = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_INIT;
         end else begin
            state_d = ST_RUN;
         end
      end else if (state_q == ST_FLUSH) begin
         dfl = 1'b1;
         if (fcnt_q == 2'd0) begin
            state_d = ST_RUN;
         end else begin
            fcnt_d = fcnt_q - 2'd1;
         end
      end else if (raw_hit) begin
         f_en      = 1'b0;
         d_en      = 1'b0;
         efl       = 1'b1;
         raw_stall = 1'b1;
      end else if (!ihit) begin
         f_en = 1'b0;
         dfl  = 1'b1;
      end
   end

   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      fwd_rs_c = 3'd0;
      fwd_rt_c = 3'd0;
      if ((FWD != 0) && !raw_stall) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_rs[k]) fwd_rs_c = 3'(k + 1);
            if (match_rt[k]) fwd_rt_c = 3'(k + 1);
         end
      end
   end

   always_comb begin
      sb_valid_d = sb_valid_q;
      sb_load_d  = sb_load_q;
      for (int k = 0; k < DEPTH; k++) sb_reg_d[k] = sb_reg_q[k];
      if (m_en) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            sb_valid_d[k] = sb_valid_q[k-1];
            sb_load_d[k]  = sb_load_q[k-1];
            sb_reg_d[k]   = sb_reg_q[k-1];
         end
         if (e_en && !efl) begin
            sb_valid_d[0] = rd_wen && (rd != '0);
            sb_load_d[0]  = rd_load;
            sb_reg_d[0]   = rd;
         end else begin
            sb_valid_d[0] = 1'b0;
            sb_load_d[0]  = 1'b0;
            sb_reg_d[0]   = '0;
         end
      end
   end

   assign stall_d = (!f_en && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= ST_RUN;
         fcnt_q     <= 2'd0;
         sb_valid_q <= '0;
         sb_load_q  <= '0;
         for (int k = 0; k < DEPTH; k++) sb_reg_q[k] <= '0;
         stall_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         sb_valid_q <= sb_valid_d;
         sb_load_q  <= sb_load_d;
         for (int k = 0; k < DEPTH; k++) sb_reg_q[k] <= sb_reg_d[k];
         stall_q    <= stall_d;
      end
   end

   // Outputs are held inactive for as long as reset is asserted.
   assign fetch_en     = nRST && f_en;
   assign decode_en    = nRST && d_en;
   assign execute_en   = nRST && e_en;
   assign memory_en    = nRST && m_en;
   assign dflush       = nRST && dfl;
   assign eflush       = nRST && efl;
   assign fwd_rs       = nRST ? fwd_rs_c : 3'd0;
   assign fwd_rt       = nRST ? fwd_rt_c : 3'd0;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dreq, dhit, rs_valid, rt_valid, rd_wen, rd_load, br_taken;
   logic [4:0] rs, rt, rd;

   logic       f0, d0, e0, m0, df0, ef0;
   logic [2:0] frs0, frt0;
   logic [15:0] st0;
   logic       f1, d1, e1, m1, df1, ef1;
   logic [2:0] frs1, frt1;
   logic [15:0] st1;

   always #5 CLK = ~CLK;

   // dut0: stall on any RAW, three-cycle branch flush
   hazard_ctrl #(.REGS(32), .DEPTH(3), .FWD(0), .FLUSH_CYCLES(3)) dut0 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dreq(dreq), .dhit(dhit),
      .rs_valid(rs_valid), .rt_valid(rt_valid), .rs(rs), .rt(rt),
      .rd_wen(rd_wen), .rd(rd), .rd_load(rd_load), .br_taken(br_taken),
      .fetch_en(f0), .decode_en(d0), .execute_en(e0), .memory_en(m0),
      .dflush(df0), .eflush(ef0), .fwd_rs(frs0), .fwd_rt(frt0), .stall_cycles(st0)
   );

   // dut1: forwarding, single-cycle branch flush
   hazard_ctrl #(.REGS(32), .DEPTH(3), .FWD(1), .FLUSH_CYCLES(1)) dut1 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dreq(dreq), .dhit(dhit),
      .rs_valid(rs_valid), .rt_valid(rt_valid), .rs(rs), .rt(rt),
      .rd_wen(rd_wen), .rd(rd), .rd_load(rd_load), .br_taken(br_taken),
      .fetch_en(f1), .decode_en(d1), .execute_en(e1), .memory_en(m1),
      .dflush(df1), .eflush(ef1), .fwd_rs(frs1), .fwd_rt(frt1), .stall_cycles(st1)
   );

   typedef struct {
      int          sel;
      logic [27:0] exp;
      string       nm;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   logic [27:0] act;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Monitor: one expectation per checked cycle, compared mid-cycle.
   always @(negedge CLK) begin
      if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         act = (cur.sel != 0) ? {f1, d1, e1, m1, df1, ef1, frs1, frt1, st1}
                              : {f0, d0, e0, m0, df0, ef0, frs0, frt0, st0};
         n_tests++;
         if (act !== cur.exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got en=%b df=%b ef=%b frs=%0d frt=%0d st=%0d, want en=%b df=%b ef=%b frs=%0d frt=%0d st=%0d",
                     cur.nm, cur.sel, act[27:24], act[23], act[22], act[21:19], act[18:16], act[15:0],
                     cur.exp[27:24], cur.exp[23], cur.exp[22], cur.exp[21:19], cur.exp[18:16], cur.exp[15:0]);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cyc(input string nm, input int sel, input logic [3:0] en, input logic df,
                      input logic ef, input logic [2:0] frs, input logic [2:0] frt,
                      input logic [15:0] st);
      exp_t e;
      e.sel = sel;
      e.exp = {en, df, ef, frs, frt, st};
      e.nm  = nm;
      exp_q.push_back(e);
      tick();
   endtask

   task automatic ctl(input logic ih, input logic dq, input logic dh, input logic br);
      ihit = ih; dreq = dq; dhit = dh; br_taken = br;
   endtask

   task automatic src(input logic sv, input logic [4:0] s, input logic tv, input logic [4:0] t);
      rs_valid = sv; rs = s; rt_valid = tv; rt = t;
   endtask

   task automatic dst(input logic w, input logic [4:0] r, input logic ld);
      rd_wen = w; rd = r; rd_load = ld;
   endtask

   initial begin
      nRST = 1'b0;
      ctl(0, 0, 0, 0);
      src(0, 0, 0, 0);
      dst(0, 0, 0);
      tick();
      cyc("rst_outs0", 0, 4'h0, 0, 0, 0, 0, 0);
      cyc("rst_outs1", 1, 4'h0, 0, 0, 0, 0, 0);
      nRST = 1'b1;

      // FWD=0 RAW: addi r2 then add r3,r2,r1 stalls DEPTH cycles
      ctl(1, 0, 0, 0);
      dst(1, 2, 0);
      cyc("raw_prod", 0, 4'hF, 0, 0, 0, 0, 0);
      src(1, 2, 1, 1);
      dst(1, 3, 0);
      cyc("raw_stall1", 0, 4'b0011, 0, 1, 0, 0, 0);
      cyc("raw_stall2", 0, 4'b0011, 0, 1, 0, 0, 1);
      cyc("raw_stall3", 0, 4'b0011, 0, 1, 0, 0, 2);
      cyc("raw_issue", 0, 4'hF, 0, 0, 0, 0, 3);

      // Fill the scoreboard, then reset mid-run
      src(0, 0, 0, 0);
      dst(1, 4, 0);
      cyc("fill_r4", 0, 4'hF, 0, 0, 0, 0, 3);
      dst(1, 5, 0);
      cyc("fill_r5", 0, 4'hF, 0, 0, 0, 0, 3);
      nRST = 1'b0;
      cyc("rst_mid", 0, 4'h0, 0, 0, 0, 0, 0);
      nRST = 1'b1;
      src(1, 3, 1, 4);
      dst(0, 0, 0);
      cyc("rst_sb_clear", 0, 4'hF, 0, 0, 0, 0, 0);

      // Taken branch with FLUSH_CYCLES=3
      src(0, 0, 0, 0);
      ctl(1, 0, 0, 1);
      cyc("br_cycle", 0, 4'hF, 1, 1, 0, 0, 0);
      ctl(1, 0, 0, 0);
      cyc("br_flush1", 0, 4'hF, 1, 0, 0, 0, 0);
      cyc("br_flush2", 0, 4'hF, 1, 0, 0, 0, 0);
      cyc("br_run", 0, 4'hF, 0, 0, 0, 0, 0);

      // Data wait outranks a pending branch and a RAW match
      dst(1, 7, 0);
      cyc("wr_r7", 0, 4'hF, 0, 0, 0, 0, 0);
      dst(0, 0, 0);
      src(1, 7, 0, 0);
      ctl(1, 1, 0, 1);
      for (int i = 0; i < 4; i++) cyc("dwait", 0, 4'h0, 0, 0, 0, 0, 16'(i));
      ctl(1, 1, 1, 1);
      cyc("dwait_br", 0, 4'hF, 1, 1, 0, 0, 4);
      src(0, 0, 0, 0);
      ctl(1, 0, 0, 0);
      cyc("dwait_fl1", 0, 4'hF, 1, 0, 0, 0, 4);
      cyc("dwait_fl2", 0, 4'hF, 1, 0, 0, 0, 4);
      cyc("dwait_run", 0, 4'hF, 0, 0, 0, 0, 4);

      // FWD=1: load-use stalls once then forwards; ALU result forwards at once
      nRST = 1'b0;
      cyc("rst_fwd", 1, 4'h0, 0, 0, 0, 0, 0);
      nRST = 1'b1;
      dst(1, 4, 1);
      cyc("lw_r4", 1, 4'hF, 0, 0, 0, 0, 0);
      src(1, 4, 1, 4);
      dst(1, 5, 0);
      cyc("lu_stall", 1, 4'b0011, 0, 1, 0, 0, 0);
      cyc("lu_fwd", 1, 4'hF, 0, 0, 2, 2, 1);
      src(0, 0, 0, 0);
      dst(1, 6, 0);
      cyc("addi_r6", 1, 4'hF, 0, 0, 0, 0, 1);
      src(1, 6, 0, 0);
      dst(0, 0, 0);
      cyc("use_r6", 1, 4'hF, 0, 0, 1, 0, 1);
      src(0, 0, 0, 0);
      ctl(1, 0, 0, 1);
      cyc("br_single", 1, 4'hF, 1, 1, 0, 0, 1);
      ctl(1, 0, 0, 0);
      cyc("br_single_run", 1, 4'hF, 0, 0, 0, 0, 1);

      // Long fetch miss: stall counter saturates
      nRST = 1'b0;
      cyc("rst_long", 0, 4'h0, 0, 0, 0, 0, 0);
      nRST = 1'b1;
      ctl(0, 0, 0, 0);
      for (int i = 0; i < 70000; i++) begin
         if (i == 0 || i == 1 || i == 65534 || i == 65535 || i == 65536 || i == 69999)
            cyc("ihit_miss", 0, 4'b0111, 1, 0, 0, 0, (i > 65535) ? 16'hFFFF : 16'(i));
         else
            tick();
      end

      ctl(1, 0, 0, 0);
      tick();
      tick();
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
